// File: rtl/phase_timer.sv
// Phase countdown timer for a traffic-light controller: loads a two-digit BCD
// duration and counts it down once per TICKS_PER_SEC clocks, with hold and abort.
module phase_timer #(
    parameter int TICKS_PER_SEC = 50
) (
    input  logic       Clk,
    input  logic       R,
    input  logic       Load,
    input  logic [3:0] Dur_H,
    input  logic [3:0] Dur_L,
    input  logic       Hold,
    input  logic       Abort,
    output logic [3:0] Time_H,
    output logic [3:0] Time_L,
    output logic       Busy,
    output logic       finished,
    output logic [1:0] Dbg_state
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] psc;
    logic [3:0]    ld_h;
    logic [3:0]    ld_l;
    logic          ld_zero;

    // Digits above 9 are clamped at capture so the count stays valid BCD.
    always_comb begin
        ld_h    = (Dur_H > 4'd9) ? 4'd9 : Dur_H;
        ld_l    = (Dur_L > 4'd9) ? 4'd9 : Dur_L;
        ld_zero = (ld_h == 4'd0) && (ld_l == 4'd0);
    end

    assign Dbg_state = state;

    always_ff @(posedge Clk) begin
        if (R) begin
            state    <= IDLE;
            psc      <= '0;
            Time_H   <= 4'd0;
            Time_L   <= 4'd0;
            Busy     <= 1'b0;
            finished <= 1'b0;
        end else begin
            finished <= 1'b0;
            if (Abort) begin
                state  <= IDLE;
                psc    <= '0;
                Time_H <= 4'd0;
                Time_L <= 4'd0;
                Busy   <= 1'b0;
            end else if (Load) begin
                psc <= '0;
                if (ld_zero) begin
                    // A zero-length phase completes at once; never pulse twice in a row.
                    state    <= IDLE;
                    Time_H   <= 4'd0;
                    Time_L   <= 4'd0;
                    Busy     <= 1'b0;
                    finished <= ~finished;
                end else begin
                    state  <= RUN;
                    Time_H <= ld_h;
                    Time_L <= ld_l;
                    Busy   <= 1'b1;
                end
            end else begin
                case (state)
                    RUN, HOLD: begin
                        if (Hold) begin
                            state <= HOLD;
                        end else begin
                            // Releasing hold counts on the same edge, so hold delays by exactly its length.
                            state <= RUN;
                            if (psc == PSC_LAST) begin
                                psc <= '0;
                                if (Time_H == 4'd0 && Time_L <= 4'd1) begin
                                    state    <= IDLE;
                                    Time_H   <= 4'd0;
                                    Time_L   <= 4'd0;
                                    Busy     <= 1'b0;
                                    finished <= ~finished;
                                end else if (Time_L != 4'd0) begin
                                    Time_L <= Time_L - 4'd1;
                                end else begin
                                    Time_L <= 4'd9;
                                    Time_H <= Time_H - 4'd1;
                                end
                            end else begin
                                psc <= psc + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50, meaning Clk cycles per one-second decrement (minimum 2).
REQ-002 SHALL have port Clk, input, 1, meaning the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port R, input, 1, meaning synchronous active-high reset.
REQ-004 SHALL have port Load, input, 1, meaning a one-cycle request from the light controller to start a phase countdown.
REQ-005 SHALL have port Dur_H, input, 4, meaning the BCD tens digit of the phase duration, sampled on Load.
REQ-006 SHALL have port Dur_L, input, 4, meaning the BCD units digit of the phase duration, sampled on Load.
REQ-007 SHALL have port Hold, input, 1, meaning police override; freezes the countdown while high.
REQ-008 SHALL have port Abort, input, 1, meaning cancel the countdown immediately with no finished pulse.
REQ-009 SHALL have port Time_H, output, 4, meaning the BCD tens digit of the remaining seconds.
REQ-010 SHALL have port Time_L, output, 4, meaning the BCD units digit of the remaining seconds.
REQ-011 SHALL have port Busy, output, 1, meaning the countdown is active (RUN or HOLD).
REQ-012 SHALL have port finished, output, 1, meaning a one-cycle pulse when the countdown reaches 00.

Function
REQ-013 SHALL implement states IDLE, RUN and HOLD; all outputs SHALL be registered.
REQ-014 In IDLE with Load=1, SHALL capture the duration and clear the prescaler; on the next cycle Time_H/Time_L SHALL show the loaded value and Busy=1 (state RUN).
REQ-015 SHALL clamp any duration digit greater than 9 to 9 at capture.
REQ-016 If Load arrives with duration 00, SHALL stay in IDLE, keep Time=00, and assert finished for one cycle on the next edge.
REQ-017 In RUN, the prescaler SHALL count 0..TICKS_PER_SEC-1 and wrap; the wrap edge is the second tick.
REQ-018 On a second tick, SHALL decrement in BCD: if Time_L is nonzero, Time_L-1; otherwise Time_L=9 and Time_H-1.
REQ-019 On the tick that takes Time from 01 to 00, SHALL register finished=1 for exactly one cycle and return to IDLE (Busy=0) on the same edge.
REQ-020 Load during RUN or HOLD SHALL restart the countdown with the new duration, clear the prescaler, and go to RUN; no finished pulse is produced for the interrupted phase.
REQ-021 Hold=1 in RUN SHALL move to HOLD; the prescaler and Time SHALL be frozen and Busy held at 1.
REQ-022 Hold=0 in HOLD SHALL return to RUN, resuming from the frozen prescaler value.
REQ-023 Hold in IDLE SHALL have no effect.
REQ-024 Abort=1 in any state SHALL go to IDLE on the next edge with Time=00, Busy=0, prescaler=0, and finished=0.
REQ-025 Priority SHALL be R > Abort > Load > Hold > tick.
REQ-026 Time SHALL never wrap below 00 and finished SHALL never be asserted for two consecutive cycles.

Reset
REQ-027 On R=1 at a clock edge, SHALL set: state=IDLE, Time_H=0, Time_L=0, Busy=0, finished=0, prescaler=0, regardless of any in-progress countdown.
REQ-028 SHALL ignore Load, Hold and Abort in the same cycle as R=1.

Verification (TICKS_PER_SEC=4)
REQ-029 Load with 05 at edge 0 -> Time=05 and Busy=1 after edge 1; Time=04 after edge 4; Time=00 with finished=1 after edge 20; Busy=0 after edge 20; finished=0 after edge 21.
REQ-030 Load 10 -> after 4 ticks Time=09 (borrow across digits); Load with Dur_H=0xC, Dur_L=0xF -> Time=99.
REQ-031 Load 03, Hold=1 for 10 cycles starting edge 2 -> Time frozen and Busy=1 throughout; finished delayed by exactly 10 cycles (edge 22).
REQ-032 Load 05, Load 02 at edge 6 -> no finished near edge 20; finished after edge 14 only.
REQ-033 Load 05, Abort at edge 9 -> Time=00 and Busy=0 after edge 10; no finished pulse ever; Load 00 -> finished after next edge, Busy stays 0.
REQ-034 R=1 at edge 7 of a countdown of 05 (with Load also high) -> all outputs 0 after edge 8; no further activity until the next Load.
